// File: rtl/mcx_pkg.sv
// Shared MCX definitions used by the cores and by the XBus arbiter.
// Contents:
//   DW_DEFAULT    - data width of the signed MCX accumulator
//   xbus_state_e  - arbiter FSM states
//   ADDR_*        - MCX register/port addresses
//   is_xbus_addr  - true when an address selects an XBus pin
package mcx_pkg;

    localparam int DW_DEFAULT = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        RECOVER = 2'd2
    } xbus_state_e;

    localparam logic [11:0] ADDR_ACC = 12'h801;
    localparam logic [11:0] ADDR_DAT = 12'h802;
    localparam logic [11:0] ADDR_P0  = 12'h803;
    localparam logic [11:0] ADDR_P1  = 12'h804;
    localparam logic [11:0] ADDR_X0  = 12'h805;
    localparam logic [11:0] ADDR_X1  = 12'h806;
    localparam logic [11:0] ADDR_X2  = 12'h807;
    localparam logic [11:0] ADDR_X3  = 12'h808;

    // The X0..X3 pins are the ones routed through the XBus arbiter.
    function automatic logic is_xbus_addr(input logic [11:0] addr);
        return (addr >= ADDR_X0) && (addr <= ADDR_X3);
    endfunction

endpackage

// File: rtl/xbus_arbiter_rr_pick.sv
// Circular priority pick: returns the first set bit of req_i, searching
// upward from ptr_i and wrapping at N-1 -> 0.
// Ports:
//   req_i   [N-1:0]  candidate vector
//   ptr_i   [PW-1:0] search start index (0..N-1)
//   idx_o   [PW-1:0] selected index (0 when nothing is found)
//   found_o          at least one bit of req_i is set
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] idx_o,
    output logic          found_o
);

    // (base + k) mod N, for base < N and k < N.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) begin
            s = s - N;
        end else begin
            s = s;
        end
        return PW'(s);
    endfunction

    // Scan from the farthest position back to the pointer so the closest hit wins.
    always_comb begin
        idx_o   = {PW{1'b0}};
        found_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[wrap_add(ptr_i, k)]) begin
                idx_o   = wrap_add(ptr_i, k);
                found_o = 1'b1;
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/xbus_arbiter.sv
// XBus arbiter: pairs one pending blocking writer with one pending blocking
// reader (round-robin on each side), moves the value and acks both.
// Ports:
//   clk, nrst           clock, async active-low reset
//   wr_req / rd_req     per-client level requests, held until acked
//   wr_data             per-client write values, slice i = [i*DW +: DW]
//   wr_ack / rd_ack     one-cycle ack pulses (rd_data valid with rd_ack)
//   rd_data             shared read value, holds between transfers
//   wr_pending          a legal write is waiting (core wake source)
//   err                 sticky: client raised wr_req and rd_req together
//   xfer_count          completed transfers, wrapping
module xbus_arbiter
    import mcx_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int DW          = DW_DEFAULT,
    parameter int CW          = 16
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [NUM_CLIENTS-1:0]    wr_req,
    input  logic [NUM_CLIENTS*DW-1:0] wr_data,
    input  logic [NUM_CLIENTS-1:0]    rd_req,
    output logic [NUM_CLIENTS-1:0]    wr_ack,
    output logic [NUM_CLIENTS-1:0]    rd_ack,
    output logic [DW-1:0]             rd_data,
    output logic                      wr_pending,
    output logic [NUM_CLIENTS-1:0]    err,
    output logic [CW-1:0]             xfer_count
);

    localparam int             PW       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [PW-1:0]  LAST_IDX = PW'(NUM_CLIENTS - 1);
    localparam logic [PW-1:0]  IDX_ONE  = PW'(32'd1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);

    xbus_state_e            state_q, state_d;
    logic [PW-1:0]          gw_q, gw_d, gr_q, gr_d;
    logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DW-1:0]          wbuf_q, wbuf_d;
    logic [NUM_CLIENTS-1:0] wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
    logic [DW-1:0]          rd_data_q, rd_data_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_CLIENTS-1:0] err_q;

    logic [NUM_CLIENTS-1:0] conflict_s, w_s, r_s;
    logic [PW-1:0]          sel_w_s, sel_r_s;
    logic                   found_w_s, found_r_s;
    logic [DW-1:0]          wdat_s [NUM_CLIENTS];

    function automatic logic [NUM_CLIENTS-1:0] onehot(input logic [PW-1:0] idx);
        logic [NUM_CLIENTS-1:0] one;
        one = {{(NUM_CLIENTS-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        if (idx == LAST_IDX) begin
            return {PW{1'b0}};
        end else begin
            return idx + IDX_ONE;
        end
    endfunction

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
        assign wdat_s[i] = wr_data[i*DW +: DW];
    end

    // A client asking both ways at once is excluded from both sides.
    assign conflict_s = wr_req & rd_req;
    assign w_s        = wr_req & ~conflict_s;
    assign r_s        = rd_req & ~conflict_s;
    assign wr_pending = |w_s;

    rr_pick #(.N(NUM_CLIENTS), .PW(PW)) u_pick_w (
        .req_i   (w_s),
        .ptr_i   (wptr_q),
        .idx_o   (sel_w_s),
        .found_o (found_w_s)
    );

    rr_pick #(.N(NUM_CLIENTS), .PW(PW)) u_pick_r (
        .req_i   (r_s),
        .ptr_i   (rptr_q),
        .idx_o   (sel_r_s),
        .found_o (found_r_s)
    );

    // Next-state and next-output logic of the transfer FSM.
    always_comb begin
        state_d   = state_q;
        gw_d      = gw_q;
        gr_d      = gr_q;
        wbuf_d    = wbuf_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        wr_ack_d  = {NUM_CLIENTS{1'b0}};
        rd_ack_d  = {NUM_CLIENTS{1'b0}};
        rd_data_d = rd_data_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                // Write value is captured here; later changes do not matter.
                if (found_w_s && found_r_s) begin
                    gw_d    = sel_w_s;
                    gr_d    = sel_r_s;
                    wbuf_d  = wdat_s[sel_w_s];
                    state_d = XFER;
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                wr_ack_d  = onehot(gw_q);
                rd_ack_d  = onehot(gr_q);
                rd_data_d = wbuf_q;
                cnt_d     = cnt_q + CNT_ONE;
                wptr_d    = next_idx(gw_q);
                rptr_d    = next_idx(gr_q);
                state_d   = RECOVER;
            end
            RECOVER: begin
                // Acks are visible now; clients drop their reqs before next IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            gw_q      <= {PW{1'b0}};
            gr_q      <= {PW{1'b0}};
            wptr_q    <= {PW{1'b0}};
            rptr_q    <= {PW{1'b0}};
            wbuf_q    <= {DW{1'b0}};
            wr_ack_q  <= {NUM_CLIENTS{1'b0}};
            rd_ack_q  <= {NUM_CLIENTS{1'b0}};
            rd_data_q <= {DW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            err_q     <= {NUM_CLIENTS{1'b0}};
        end else begin
            state_q   <= state_d;
            gw_q      <= gw_d;
            gr_q      <= gr_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            wbuf_q    <= wbuf_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
            cnt_q     <= cnt_d;
            err_q     <= err_q | conflict_s;
        end
    end

    assign wr_ack     = wr_ack_q;
    assign rd_ack     = rd_ack_q;
    assign rd_data    = rd_data_q;
    assign err        = err_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
module tb_xbus_arbiter;

    logic        clk;
    logic        nrst;
    logic [3:0]  wr_req;
    logic [3:0]  rd_req;
    logic [43:0] wr_data;
    logic [3:0]  wr_ack, rd_ack, err;
    logic [10:0] rd_data;
    logic        wr_pending;
    logic [15:0] xfer_count;

    logic [3:0]  wr_ack2, rd_ack2, err2;
    logic [10:0] rd_data2;
    logic        wr_pending2;
    logic [1:0]  cnt2;

    typedef struct {
        logic [3:0]  wa;
        logic [3:0]  ra;
        logic [10:0] d;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc;

    xbus_arbiter #(.NUM_CLIENTS(4), .DW(11), .CW(16)) u_dut (
        .clk(clk), .nrst(nrst), .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
        .wr_ack(wr_ack), .rd_ack(rd_ack), .rd_data(rd_data), .wr_pending(wr_pending),
        .err(err), .xfer_count(xfer_count)
    );

    // Narrow-counter copy, used only for the wrap behaviour.
    xbus_arbiter #(.NUM_CLIENTS(4), .DW(11), .CW(2)) u_dut_w (
        .clk(clk), .nrst(nrst), .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
        .wr_ack(wr_ack2), .rd_ack(rd_ack2), .rd_data(rd_data2), .wr_pending(wr_pending2),
        .err(err2), .xfer_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ack pulse must match the oldest expected transfer.
    always @(negedge clk) begin
        if (nrst && (wr_ack != 4'd0 || rd_ack != 4'd0)) begin
            if (q.size() == 0) begin
                check("unexpected_ack", {24'd0, wr_ack, rd_ack}, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("wr_ack", {28'd0, wr_ack}, {28'd0, mon_e.wa});
                check("rd_ack", {28'd0, rd_ack}, {28'd0, mon_e.ra});
                check("rd_data", {21'd0, rd_data}, {21'd0, mon_e.d});
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Wait until the scoreboard drains; returns the number of cycles taken.
    task automatic wait_drain(input int budget, output int cycles);
        cycles = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0) begin
                cycles = c;
                break;
            end
        end
        if (cycles < 0) begin
            check("timeout", q.size(), 32'd0);
            q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        nrst = 1'b0;
        tick(2);
        nrst = 1'b1;
    endtask

    task automatic expect_xfer(input logic [3:0] wa, input logic [3:0] ra, input logic [10:0] d);
        exp_t e;
        e.wa = wa;
        e.ra = ra;
        e.d  = d;
        q.push_back(e);
    endtask

    task automatic set_wdata(input int i, input logic [10:0] v);
        wr_data[i*11 +: 11] = v;
    endtask

    initial begin
        nrst    = 1'b0;
        wr_req  = 4'd0;
        rd_req  = 4'd0;
        wr_data = 44'd0;
        #12;
        check("rst_wr_ack", {28'd0, wr_ack}, 32'd0);
        check("rst_rd_ack", {28'd0, rd_ack}, 32'd0);
        check("rst_rd_data", {21'd0, rd_data}, 32'd0);
        check("rst_err", {28'd0, err}, 32'd0);
        check("rst_count", {16'd0, xfer_count}, 32'd0);
        do_reset();
        tick(1);

        // Basic: client0 writes 123 to client2.
        set_wdata(0, 11'sd123);
        wr_req = 4'b0001;
        rd_req = 4'b0100;
        expect_xfer(4'b0001, 4'b0100, 11'd123);
        wait_drain(10, cyc);
        check("basic_latency", cyc, 32'd2);
        check("basic_count", {16'd0, xfer_count}, 32'd1);
        wr_req = 4'd0;
        rd_req = 4'd0;
        tick(6);
        check("basic_no_more", {16'd0, xfer_count}, 32'd1);
        check("basic_rd_hold", {21'd0, rd_data}, 32'd123);
        check("basic_pending", {31'd0, wr_pending}, 32'd0);

        // Fairness: writers 0/1 (5, 7) alternate into reader 3.
        do_reset();
        tick(1);
        set_wdata(0, 11'd5);
        set_wdata(1, 11'd7);
        wr_req = 4'b0011;
        rd_req = 4'b1000;
        expect_xfer(4'b0001, 4'b1000, 11'd5);
        expect_xfer(4'b0010, 4'b1000, 11'd7);
        expect_xfer(4'b0001, 4'b1000, 11'd5);
        expect_xfer(4'b0010, 4'b1000, 11'd7);
        wait_drain(40, cyc);
        wr_req = 4'd0;
        rd_req = 4'd0;
        tick(3);
        check("fair_count", {16'd0, xfer_count}, 32'd4);

        // Negative value; fifth transfer since reset wraps the 2-bit counter to 1.
        set_wdata(0, -11'sd999);
        wr_req = 4'b0001;
        rd_req = 4'b0100;
        expect_xfer(4'b0001, 4'b0100, 11'h419);
        wait_drain(10, cyc);
        wr_req = 4'd0;
        rd_req = 4'd0;
        tick(3);
        check("neg_rd_data", {21'd0, rd_data}, 32'h419);
        check("count_5", {16'd0, xfer_count}, 32'd5);
        check("wrap_count", {30'd0, cnt2}, 32'd1);

        // Blocking: lone writer waits, then is served by a reader.
        set_wdata(1, 11'h2AA);
        wr_req = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("block_pending", {31'd0, wr_pending}, 32'd1);
        end
        rd_req = 4'b0001;
        expect_xfer(4'b0010, 4'b0001, 11'h2AA);
        wait_drain(10, cyc);
        check("block_latency", cyc, 32'd2);
        wr_req = 4'd0;
        rd_req = 4'd0;
        tick(3);
        check("block_err", {28'd0, err}, 32'd0);

        // Illegal: client2 requests both ways while client0 reads.
        set_wdata(2, 11'h155);
        wr_req = 4'b0100;
        rd_req = 4'b0101;
        tick(1);
        check("illegal_pending", {31'd0, wr_pending}, 32'd0);
        tick(5);
        check("illegal_err", {28'd0, err}, 32'h4);
        check("illegal_count", {16'd0, xfer_count}, 32'd6);
        rd_req = 4'b0001;
        expect_xfer(4'b0100, 4'b0001, 11'h155);
        wait_drain(10, cyc);
        wr_req = 4'd0;
        rd_req = 4'd0;
        tick(3);
        check("illegal_sticky", {28'd0, err}, 32'h4);

        // Reset during XFER: aborted, then redone from pointers 0.
        set_wdata(1, 11'h3C3);
        set_wdata(3, 11'h0AB);
        wr_req = 4'b1010;
        rd_req = 4'b0101;
        tick(1);
        nrst = 1'b0;
        #1;
        check("mid_wr_ack", {28'd0, wr_ack}, 32'd0);
        check("mid_rd_ack", {28'd0, rd_ack}, 32'd0);
        check("mid_count", {16'd0, xfer_count}, 32'd0);
        check("mid_err", {28'd0, err}, 32'd0);
        tick(2);
        nrst = 1'b1;
        expect_xfer(4'b0010, 4'b0001, 11'h3C3);
        wait_drain(10, cyc);
        wr_req = 4'd0;
        rd_req = 4'd0;
        tick(4);
        check("post_rst_count", {16'd0, xfer_count}, 32'd1);
        check("post_rst_wrap", {30'd0, cnt2}, 32'd1);
        check("post_rst_data", {21'd0, rd_data}, 32'h3C3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xbus_arbiter.md
Name: xbus_arbiter

Overview:
- Shared blocking-handshake channel ("XBus") between up to NUM_CLIENTS MCX cores.
- Each client posts a blocking write (value) or a blocking read. The arbiter pairs one pending writer with one pending reader round-robin, moves the value, and acks both.
- Sits between the MCX port logic and the bus wiring; it replaces ad-hoc point-to-point port tristating for XBus-type pins.

Parameters:
- NUM_CLIENTS, 4, number of attached cores (2..8).
- DW, 11, data width; matches the signed MCX acc width.
- CW, 16, width of the transfer counter.

Ports:
- clk  input  1  system clock.
- nrst  input  1  reset, asynchronous, active-low.
- wr_req  input  NUM_CLIENTS  per-client blocking write request; held until the matching wr_ack.
- wr_data  input  NUM_CLIENTS*DW  per-client write value; slice i is bits [i*DW +: DW]; held with wr_req.
- rd_req  input  NUM_CLIENTS  per-client blocking read request; held until the matching rd_ack.
- wr_ack  output  NUM_CLIENTS  one-cycle pulse; the write is consumed.
- rd_ack  output  NUM_CLIENTS  one-cycle pulse; rd_data is valid this cycle.
- rd_data  output  DW  shared read value; holds its last value between transfers.
- wr_pending  output  1  a legal wr_req is pending; used as the wake source for sleeping cores.
- err  output  NUM_CLIENTS  sticky; client i asserted wr_req and rd_req in the same cycle.
- xfer_count  output  CW  number of completed transfers; wraps.

Behaviour:
- Reset (async, nrst low), all outputs and state forced immediately:
  - state=IDLE; wr_ack=0, rd_ack=0, rd_data=0, err=0, xfer_count=0.
  - wptr=0, rptr=0; latched grants cleared.
  - Reset mid-XFER aborts the transfer: no ack is produced and the counter does not change.
- Legal request sets:
  - legal_i = ~(wr_req[i] & rd_req[i]).
  - W = wr_req & legal; R = rd_req & legal.
  - Any cycle with wr_req[i]&rd_req[i] sets err[i]; it stays set until reset. That client is excluded from both sides while the condition holds.
- wr_pending = |W (combinational from inputs); valid in every state.
- Round-robin select: lowest index j, searching circularly from the pointer, with the bit set. Writer search uses W from wptr; reader search uses R from rptr.
- FSM states IDLE, XFER, RECOVER:
  - IDLE: if |W and |R, latch gw=sel_w, gr=sel_r and wbuf=wr_data[gw]; go to XFER. Otherwise stay in IDLE.
  - XFER (exactly 1 cycle): assert wr_ack[gw]=1 and rd_ack[gr]=1 (registered outputs, so they appear as the state is entered). rd_data=wbuf. xfer_count+=1. wptr=(gw+1) mod NUM_CLIENTS, rptr=(gr+1) mod NUM_CLIENTS. Go to RECOVER.
  - RECOVER (1 cycle): acks=0 and no arbitration, which gives acked clients one cycle to drop their req. Go to IDLE.
- Latency: a request pair first sampled in IDLE at edge t gets acks high during the cycle after edge t+1. Minimum spacing between transfers is 3 cycles.
- Requests are level; a request that drops before its ack is simply not served. There is no partial state.
- A requester that keeps its req high across RECOVER is treated as a new request (back-to-back transfers are legal).
- Only one pair moves per transfer. With 2 writers and 2 readers pending, the second pair is served in the next IDLE.
- gw==gr cannot occur, because such a client is illegal and excluded.
- wr_data for the granted writer is sampled only in IDLE. Changes to it after that do not affect the transfer.
- Signedness: the arbiter passes data through opaquely and does no arithmetic on it.

Decomposition:
- Shared package mcx_pkg:
  - DW default.
  - State enum {IDLE, XFER, RECOVER}.
  - The port-address constants already used by MCX (acc 0x801 and the port addresses), so cores and the arbiter agree on which address selects the XBus.
- One sub-module: rr_pick (NUM_CLIENTS-wide circular priority pick; inputs vector and pointer, outputs index and found). It is instantiated twice, once for writers and once for readers.

Test Plan:
- Basic transfer: client0 wr_req with wr_data=11'sd123 and client2 rd_req, held → 2 cycles after they are first sampled, wr_ack=0001, rd_ack=0100, rd_data=123, xfer_count=1; then RECOVER; nothing further once the reqs drop.
- Fairness: clients 0 and 1 write (values 5 and 7) continuously and client3 reads continuously for 4 transfers → rd_data sequence 5,7,5,7; writer acks alternate 0001,0010.
- Blocking: wr_req from client1 only, for 20 cycles → no ack; wr_pending=1 throughout. Then client0 rd_req → acks within 2 cycles and rd_data equals client1's value.
- Illegal request: client2 asserts wr_req and rd_req together while client0 reads → err=0100 (sticky), no ack to client2, wr_pending=0. Client2 then drops rd_req → normal transfer to client0.
- Negative value and counter wrap: wr_data=-11'sd999 → rd_data=11'h419. With CW forced to 2, 5 transfers → xfer_count=1.
- Reset mid-XFER: assert nrst low in the XFER cycle → acks go low immediately and xfer_count=0. After release, both reqs are still held → the transfer completes normally with wptr and rptr starting from 0.
